// File: rtl/mem_port_arbiter.sv
// Shares one single-ported fixed-latency memory between instruction fetch (IF) and load/store (D).
// Latency: grant is combinational in the issue cycle; response arrives MEM_LAT cycles after issue.
// Backpressure: one access in flight; requests seen while busy are held off (no gnt) until idle.
//
// Ports:
//   clk_i, rst_i                         clock (rising edge), asynchronous active-high reset
//   if_req_i/if_addr_i                   fetch request, held stable until if_gnt_o
//   if_gnt_o/if_rvalid_o/if_rdata_o      fetch accept, response pulse and data (0 when idle)
//   d_req_i/d_we_i/d_be_i/d_addr_i/
//   d_wdata_i                            load/store request, held stable until d_gnt_o
//   d_gnt_o/d_rvalid_o/d_rdata_o         load/store accept, response pulse, load data (0 for stores)
//   mem_req_o/mem_we_o/mem_be_o/
//   mem_addr_o/mem_wdata_o               memory strobe and command, driven in the issue cycle only
//   mem_rdata_i                          memory read data, valid MEM_LAT cycles after issue
module mem_port_arbiter #(
    parameter int XLEN       = 32,
    parameter int ADDR_W     = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,

    input  logic                 if_req_i,
    input  logic [ADDR_W-1:0]    if_addr_i,
    output logic                 if_gnt_o,
    output logic                 if_rvalid_o,
    output logic [XLEN-1:0]      if_rdata_o,

    input  logic                 d_req_i,
    input  logic                 d_we_i,
    input  logic [XLEN/8-1:0]    d_be_i,
    input  logic [ADDR_W-1:0]    d_addr_i,
    input  logic [XLEN-1:0]      d_wdata_i,
    output logic                 d_gnt_o,
    output logic                 d_rvalid_o,
    output logic [XLEN-1:0]      d_rdata_o,

    output logic                 mem_req_o,
    output logic                 mem_we_o,
    output logic [XLEN/8-1:0]    mem_be_o,
    output logic [ADDR_W-1:0]    mem_addr_o,
    output logic [XLEN-1:0]      mem_wdata_o,
    input  logic [XLEN-1:0]      mem_rdata_i
);

    localparam int BE_W  = XLEN / 8;
    localparam int LAT_W = $clog2(MEM_LAT + 1);
    localparam int STV_W = $clog2(STARVE_MAX + 1);

    localparam logic [LAT_W-1:0] LAT_DONE   = LAT_W'(MEM_LAT);
    localparam logic [LAT_W-1:0] LAT_FIRST  = LAT_W'(1);
    localparam logic [STV_W-1:0] STARVE_TOP = STV_W'(STARVE_MAX);
    localparam logic [STV_W-1:0] STARVE_ONE = STV_W'(1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t             state_q,     state_d;
    logic [LAT_W-1:0]   lat_q,       lat_d;        // cycles elapsed since issue
    logic [STV_W-1:0]   starve_q,    starve_d;     // consecutive D wins over a waiting IF
    logic               own_dside_q, own_dside_d;  // in-flight access belongs to D
    logic               we_q,        we_d;         // in-flight access is a store
    logic               ready_q;                   // low during reset and the cycle after release

    // ------------------------------------------------------------------
    // Arbitration and response decode
    // ------------------------------------------------------------------
    logic can_issue;
    logic if_wins;
    logic gnt_if;
    logic gnt_d;
    logic issue;
    logic rsp_vld;

    always_comb begin
        can_issue = ready_q && (state_q == ST_IDLE);
        // D normally wins; a fetch that has been passed over STARVE_MAX times takes the slot.
        if_wins   = if_req_i && (!d_req_i || (starve_q == STARVE_TOP));
        gnt_if    = can_issue && if_wins;
        gnt_d     = can_issue && d_req_i && !if_wins;
        issue     = gnt_if || gnt_d;
        rsp_vld   = (state_q == ST_BUSY) && (lat_q == LAT_DONE);
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        lat_d       = lat_q;
        starve_d    = starve_q;
        own_dside_d = own_dside_q;
        we_d        = we_q;

        unique case (state_q)
            ST_IDLE: begin
                if (issue) begin
                    state_d     = ST_BUSY;
                    lat_d       = LAT_FIRST;
                    own_dside_d = gnt_d;
                    we_d        = gnt_d && d_we_i;
                end
                if (gnt_if) begin
                    starve_d = '0;
                end else if (gnt_d) begin
                    if (!if_req_i) begin
                        starve_d = '0;
                    end else if (starve_q != STARVE_TOP) begin
                        starve_d = starve_q + STARVE_ONE;
                    end
                end
            end
            ST_BUSY: begin
                if (rsp_vld) begin
                    state_d = ST_IDLE;
                    lat_d   = '0;
                end else begin
                    lat_d   = lat_q + LAT_FIRST;
                end
            end
            default: begin
                state_d = ST_IDLE;
                lat_d   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers (async reset drops any in-flight access)
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            lat_q       <= '0;
            starve_q    <= '0;
            own_dside_q <= 1'b0;
            we_q        <= 1'b0;
            ready_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            lat_q       <= lat_d;
            starve_q    <= starve_d;
            own_dside_q <= own_dside_d;
            we_q        <= we_d;
            ready_q     <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        if_gnt_o    = gnt_if;
        d_gnt_o     = gnt_d;

        mem_req_o   = issue;
        mem_we_o    = gnt_d && d_we_i;
        mem_be_o    = '0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if (gnt_d) begin
            mem_be_o    = d_be_i;
            mem_addr_o  = d_addr_i;
            mem_wdata_o = d_wdata_i;
        end else if (gnt_if) begin
            // Fetches are always full-word reads.
            mem_be_o    = {BE_W{1'b1}};
            mem_addr_o  = if_addr_i;
        end

        if_rvalid_o = rsp_vld && !own_dside_q;
        d_rvalid_o  = rsp_vld && own_dside_q;
        if_rdata_o  = if_rvalid_o ? mem_rdata_i : '0;
        // A store's completion pulse carries no data.
        d_rdata_o   = (d_rvalid_o && !we_q) ? mem_rdata_i : '0;
    end

    // ------------------------------------------------------------------
    // Protocol properties
    // ------------------------------------------------------------------
    a_gnt_onehot: assert property (@(posedge clk_i) disable iff (rst_i)
        !(if_gnt_o && d_gnt_o));

    a_gnt_idle_only: assert property (@(posedge clk_i) disable iff (rst_i)
        (if_gnt_o || d_gnt_o) |-> (state_q == ST_IDLE));

    a_rsp_onehot: assert property (@(posedge clk_i) disable iff (rst_i)
        !(if_rvalid_o && d_rvalid_o));

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    localparam int XLEN       = 32;
    localparam int ADDR_W     = 32;
    localparam int MEM_LAT    = 2;
    localparam int STARVE_MAX = 4;
    localparam int BE_W       = XLEN / 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt, if_rvalid;
    logic [XLEN-1:0]   if_rdata;
    logic              d_req, d_we;
    logic [BE_W-1:0]   d_be;
    logic [ADDR_W-1:0] d_addr;
    logic [XLEN-1:0]   d_wdata;
    logic              d_gnt, d_rvalid;
    logic [XLEN-1:0]   d_rdata;
    logic              mem_req, mem_we;
    logic [BE_W-1:0]   mem_be;
    logic [ADDR_W-1:0] mem_addr;
    logic [XLEN-1:0]   mem_wdata;
    logic [XLEN-1:0]   mem_rdata;

    mem_port_arbiter #(
        .XLEN(XLEN), .ADDR_W(ADDR_W), .MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .if_req_i(if_req), .if_addr_i(if_addr),
        .if_gnt_o(if_gnt), .if_rvalid_o(if_rvalid), .if_rdata_o(if_rdata),
        .d_req_i(d_req), .d_we_i(d_we), .d_be_i(d_be), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
        .d_gnt_o(d_gnt), .d_rvalid_o(d_rvalid), .d_rdata_o(d_rdata),
        .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_be_o(mem_be),
        .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural reference: a transaction issued in cycle N answers in
    // cycle N+MEM_LAT; the port is free again from N+MEM_LAT+1.
    // ------------------------------------------------------------------
    int          cyc        = 0;
    bit          m_ready    = 1'b0;
    bit          m_busy     = 1'b0;
    bit          m_own_d    = 1'b0;
    bit          m_we       = 1'b0;
    int          m_issue    = 0;
    int          m_starve   = 0;
    bit          m_if_wins;
    logic        e_ig, e_dg, e_ir, e_dr, e_mreq, e_mwe;
    logic [3:0]  e_be;
    logic [31:0] e_addr, e_wd, e_ird, e_drd;

    always @(negedge clk) begin
        e_ig = 0; e_dg = 0; e_ir = 0; e_dr = 0; e_mreq = 0; e_mwe = 0;
        e_be = 0; e_addr = 0; e_wd = 0; e_ird = 0; e_drd = 0;
        if (rst) begin
            m_ready  = 1'b0;
            m_busy   = 1'b0;
            m_starve = 0;
        end else if (!m_ready) begin
            m_ready = 1'b1;
        end else if (m_busy) begin
            if (cyc == m_issue + MEM_LAT) begin
                if (m_own_d) begin
                    e_dr  = 1;
                    e_drd = m_we ? 32'h0 : mem_rdata;
                end else begin
                    e_ir  = 1;
                    e_ird = mem_rdata;
                end
                m_busy = 1'b0;
            end
        end else if (if_req || d_req) begin
            m_if_wins = if_req && (!d_req || m_starve == STARVE_MAX);
            e_mreq = 1;
            if (m_if_wins) begin
                e_ig = 1; e_be = 4'hF; e_addr = if_addr;
                m_starve = 0;
            end else begin
                e_dg = 1; e_mwe = d_we; e_be = d_be; e_addr = d_addr; e_wd = d_wdata;
                m_starve = if_req ? ((m_starve < STARVE_MAX) ? m_starve + 1 : STARVE_MAX) : 0;
            end
            m_busy  = 1'b1;
            m_own_d = !m_if_wins;
            m_we    = !m_if_wins && d_we;
            m_issue = cyc;
        end
        chk("mdl_if_gnt",    if_gnt,    e_ig);
        chk("mdl_d_gnt",     d_gnt,     e_dg);
        chk("mdl_if_rvalid", if_rvalid, e_ir);
        chk("mdl_if_rdata",  if_rdata,  e_ird);
        chk("mdl_d_rvalid",  d_rvalid,  e_dr);
        chk("mdl_d_rdata",   d_rdata,   e_drd);
        chk("mdl_mem_req",   mem_req,   e_mreq);
        chk("mdl_mem_we",    mem_we,    e_mwe);
        chk("mdl_mem_be",    mem_be,    e_be);
        chk("mdl_mem_addr",  mem_addr,  e_addr);
        chk("mdl_mem_wdata", mem_wdata, e_wd);
        cyc++;
    end

    // Inputs change only just after a rising edge; checks land after the falling edge.
    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic sample();
        @(negedge clk); #1;
    endtask

    logic ig, dg;
    int   rst_cnt;

    initial begin
        rst = 1'b1; if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_be = 0;
        d_addr = 0; d_wdata = 0; mem_rdata = 0;

        // Reset state
        sample();
        chk("rst_mem_req", mem_req, 0);
        chk("rst_if_gnt",  if_gnt,  0);
        chk("rst_d_gnt",   d_gnt,   0);
        step(); rst = 1'b0;
        sample();
        step();

        // 1: asynchronous reset with requests pending
        step(); if_req = 1; if_addr = 32'h300; d_req = 1; d_we = 0; d_addr = 32'h400;
        #1 chk("t1_pre_d_gnt", d_gnt, 1);
        #1 rst = 1'b1;
        #1;
        chk("t1_async_d_gnt",   d_gnt,   0);
        chk("t1_async_if_gnt",  if_gnt,  0);
        chk("t1_async_mem_req", mem_req, 0);
        chk("t1_async_addr",    mem_addr, 0);
        step(); sample(); chk("t1_inrst_d_gnt", d_gnt, 0);
        step(); rst = 1'b0;
        sample();
        chk("t1_rel_d_gnt",   d_gnt,   0);
        chk("t1_rel_if_gnt",  if_gnt,  0);
        chk("t1_rel_mem_req", mem_req, 0);
        step(); sample(); chk("t1_first_d_gnt", d_gnt, 1);
        step(); d_req = 0; sample();
        step(); sample();
        step(); sample(); chk("t1_if_gnt", if_gnt, 1);
        step(); if_req = 0;
        repeat (3) step();

        // 2: single fetch
        step(); if_req = 1; if_addr = 32'h100;
        sample();
        chk("t2_if_gnt",   if_gnt,   1);
        chk("t2_mem_req",  mem_req,  1);
        chk("t2_mem_addr", mem_addr, 32'h100);
        chk("t2_mem_we",   mem_we,   0);
        chk("t2_mem_be",   mem_be,   4'hF);
        step(); if_req = 0; sample();
        chk("t2_rvalid_early", if_rvalid, 0);
        step(); mem_rdata = 32'h00500093; sample();
        chk("t2_if_rvalid", if_rvalid, 1);
        chk("t2_if_rdata",  if_rdata,  32'h00500093);
        chk("t2_d_rvalid",  d_rvalid,  0);
        step(); mem_rdata = 0; d_req = 1; d_we = 0; d_addr = 32'h208; sample();
        chk("t2_idle_again", d_gnt, 1);
        step(); d_req = 0;
        repeat (3) step();

        // 3: simultaneous fetch and load
        step(); if_req = 1; if_addr = 32'h104; d_req = 1; d_we = 0; d_addr = 32'h200;
        sample();
        chk("t3_d_gnt",    d_gnt,    1);
        chk("t3_if_gnt",   if_gnt,   0);
        chk("t3_mem_addr", mem_addr, 32'h200);
        step(); d_req = 0; sample();
        chk("t3_if_wait", if_gnt, 0);
        step(); mem_rdata = 32'h11223344; sample();
        chk("t3_d_rvalid",  d_rvalid,  1);
        chk("t3_d_rdata",   d_rdata,   32'h11223344);
        chk("t3_if_rvalid", if_rvalid, 0);
        step(); mem_rdata = 0; sample();
        chk("t3_if_gnt_late", if_gnt,   1);
        chk("t3_if_addr",     mem_addr, 32'h104);
        step(); if_req = 0;
        repeat (3) step();

        // 4: both held -> D at 0,3,6,9, IF at 12, D at 15
        step(); if_req = 1; if_addr = 32'h108; d_req = 1; d_we = 0; d_addr = 32'h20C;
        for (int k = 0; k < 16; k++) begin
            if (k > 0) step();
            sample();
            chk($sformatf("t4_d_gnt_%0d", k),  d_gnt,  ((k % 3 == 0) && (k != 12)) ? 1 : 0);
            chk($sformatf("t4_if_gnt_%0d", k), if_gnt, (k == 12) ? 1 : 0);
        end
        step(); if_req = 0; d_req = 0;
        repeat (3) step();

        // 5: store
        step(); d_req = 1; d_we = 1; d_be = 4'b0011; d_addr = 32'h204; d_wdata = 32'hDEADBEEF;
        sample();
        chk("t5_d_gnt",     d_gnt,     1);
        chk("t5_mem_req",   mem_req,   1);
        chk("t5_mem_we",    mem_we,    1);
        chk("t5_mem_be",    mem_be,    4'b0011);
        chk("t5_mem_addr",  mem_addr,  32'h204);
        chk("t5_mem_wdata", mem_wdata, 32'hDEADBEEF);
        step(); d_req = 0; d_we = 0; d_be = 0; d_wdata = 0; sample();
        chk("t5_busy_req", mem_req, 0);
        step(); mem_rdata = 32'hCAFEF00D; sample();
        chk("t5_d_rvalid", d_rvalid, 1);
        chk("t5_d_rdata",  d_rdata,  0);
        step(); mem_rdata = 0;
        repeat (2) step();

        // 6: reset during an in-flight load
        step(); d_req = 1; d_we = 0; d_addr = 32'h210; sample();
        chk("t6_d_gnt", d_gnt, 1);
        step(); d_req = 0; rst = 1'b1; sample();
        chk("t6_rvalid_rst1", d_rvalid, 0);
        step(); mem_rdata = 32'h55AA55AA; sample();
        chk("t6_rvalid_rst2", d_rvalid, 0);
        step(); rst = 1'b0; d_req = 1; sample();
        chk("t6_rel_gnt", d_gnt, 0);
        chk("t6_rel_rvalid", d_rvalid, 0);
        step(); sample();
        chk("t6_regnt", d_gnt, 1);
        step(); d_req = 0; sample();
        step(); mem_rdata = 32'h0BADF00D; sample();
        chk("t6_d_rvalid", d_rvalid, 1);
        chk("t6_d_rdata",  d_rdata,  32'h0BADF00D);
        step(); mem_rdata = 0;
        repeat (2) step();

        // Randomised traffic with occasional resets; the reference model checks every cycle.
        ig = 0; dg = 0; rst_cnt = 0;
        for (int i = 0; i < 3000; i++) begin
            step();
            if (rst) begin
                rst_cnt--;
                if (rst_cnt <= 0) rst = 1'b0;
            end else if ($urandom_range(0, 249) == 0) begin
                rst = 1'b1;
                rst_cnt = int'($urandom_range(1, 2));
            end
            if (if_req && ig) if_req = 0;
            if (!if_req && $urandom_range(0, 2) != 0) begin
                if_req  = 1;
                if_addr = $urandom;
            end
            if (d_req && dg) d_req = 0;
            if (!d_req && $urandom_range(0, 2) != 0) begin
                d_req   = 1;
                d_we    = 1'($urandom_range(0, 1));
                d_be    = 4'($urandom);
                d_addr  = $urandom;
                d_wdata = $urandom;
            end
            mem_rdata = $urandom;
            sample();
            ig = if_gnt;
            dg = d_gnt;
        end
        step(); rst = 1'b0; if_req = 0; d_req = 0;
        repeat (4) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
